// File: rtl/snake_gfx_pkg.sv
// Shared types and constants for the snake sprite pipeline.
// Direction enum, transparent palette key and default sprite size.
package snake_gfx_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Palette index 0 is the magenta colour key: never drawn.
    localparam logic [3:0] TRANSP_IDX = 4'h0;

    localparam int SPRITE_DIM_DEF = 16;

endpackage

// File: rtl/sprite_addr_rotate.sv
// Maps sprite-local (u,v) plus facing to an address in the up-facing image.
// Purely combinational so body and tail fetch units can share it.
module sprite_addr_rotate
    import snake_gfx_pkg::*;
#(
    parameter int SPRITE_DIM = SPRITE_DIM_DEF,
    parameter int ADDR_W     = 8,
    parameter int CW         = $clog2(SPRITE_DIM)
) (
    input  logic [CW-1:0]     u,
    input  logic [CW-1:0]     v,
    input  dir_t              dir,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [CW-1:0]     S     = CW'(SPRITE_DIM - 1);
    localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(SPRITE_DIM);

    logic [CW-1:0] col;
    logic [CW-1:0] row;

    // Rotate screen-relative coordinates back into the up-facing source image.
    always_comb begin
        col = u;
        row = v;
        unique case (dir)
            DIR_UP: begin
                col = u;
                row = v;
            end
            DIR_RIGHT: begin
                col = v;
                row = S - u;
            end
            DIR_DOWN: begin
                col = S - u;
                row = S - v;
            end
            DIR_LEFT: begin
                col = S - v;
                row = u;
            end
            default: begin
                col = u;
                row = v;
            end
        endcase
        addr = ADDR_W'(row) * DIM_A + ADDR_W'(col);
    end

endmodule

// File: rtl/snake_head_sprite_fetch.sv
// Snake-head sprite fetch: raster position to ROM address, index capture,
// opaque-hit flag and sync delay, all advancing on the pixel strobe.
module snake_head_sprite_fetch
    import snake_gfx_pkg::*;
#(
    parameter int SPRITE_DIM = SPRITE_DIM_DEF,
    parameter int ADDR_W     = 8,
    parameter int IDX_W      = 4,
    parameter int COORD_W    = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pixel_en,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               blank_in,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  dir_t               head_dir,
    input  logic               head_vis,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_data,
    output logic [IDX_W-1:0]   pal_index,
    output logic               sprite_hit,
    output logic               hs_out,
    output logic               vs_out,
    output logic               blank_out
);

    localparam int CW = $clog2(SPRITE_DIM);
    localparam logic [COORD_W:0] DIM_C = (COORD_W + 1)'(SPRITE_DIM);
    localparam logic [IDX_W-1:0] KEY   = IDX_W'(TRANSP_IDX);

    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    dir_t               sdir;
    logic               svis;
    logic               vs_prev;

    logic [COORD_W:0]   u;
    logic [COORD_W:0]   v;
    logic               in_box;
    logic [ADDR_W-1:0]  rot_addr;

    logic               hit1;
    logic               hs1;
    logic               vs1;
    logic               blank1;

    // Latch head state on the vsync falling edge so a frame draws one pose.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx      <= '0;
            sy      <= '0;
            sdir    <= DIR_UP;
            svis    <= 1'b0;
            vs_prev <= 1'b1;
        end else if (pixel_en) begin
            vs_prev <= vs_in;
            if (vs_prev && !vs_in) begin
                sx   <= head_x;
                sy   <= head_y;
                sdir <= head_dir;
                svis <= head_vis;
            end
        end
    end

    // Sprite-local offsets; the extra bit keeps edge sprites from wrapping.
    always_comb begin
        u      = {1'b0, DrawX} - {1'b0, sx};
        v      = {1'b0, DrawY} - {1'b0, sy};
        in_box = (DrawX >= sx) && (u < DIM_C)
              && (DrawY >= sy) && (v < DIM_C);
    end

    sprite_addr_rotate #(
        .SPRITE_DIM (SPRITE_DIM),
        .ADDR_W     (ADDR_W),
        .CW         (CW)
    ) u_rot (
        .u    (u[CW-1:0]),
        .v    (v[CW-1:0]),
        .dir  (sdir),
        .addr (rot_addr)
    );

    // Stage 1: issue the ROM address and carry hit qualifier plus syncs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit1     <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            blank1   <= 1'b0;
        end else if (pixel_en) begin
            rom_addr <= in_box ? rot_addr : '0;
            hit1     <= in_box & svis;
            hs1      <= hs_in;
            vs1      <= vs_in;
            blank1   <= blank_in;
        end
    end

    // Stage 2: capture ROM data and resolve transparency against the key.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pal_index  <= '0;
            sprite_hit <= 1'b0;
            hs_out     <= 1'b1;
            vs_out     <= 1'b1;
            blank_out  <= 1'b0;
        end else if (pixel_en) begin
            pal_index  <= rom_data;
            sprite_hit <= hit1 & (rom_data != KEY);
            hs_out     <= hs1;
            vs_out     <= vs1;
            blank_out  <= blank1;
        end
    end

endmodule

// File: tb/tb_snake_head_sprite_fetch.sv
// Directed and random bench for snake_head_sprite_fetch against a
// coordinate-rotation reference model and a behavioural sprite ROM.
module tb_snake_head_sprite_fetch;
    import snake_gfx_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       pixel_en = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       hs_in = 1'b1;
    logic       vs_in = 1'b1;
    logic       blank_in = 1'b0;
    logic [9:0] head_x = '0;
    logic [9:0] head_y = '0;
    dir_t       head_dir = DIR_UP;
    logic       head_vis = 1'b0;
    logic [7:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] pal_index;
    logic       sprite_hit;
    logic       hs_out;
    logic       vs_out;
    logic       blank_out;

    logic [3:0] rom [256];

    int errors = 0;
    int checks = 0;

    int m_sx, m_sy, m_dir;
    bit m_vis, m_vsp;
    int p_addr;
    bit p_hit, p_hs, p_vs, p_blank;
    int e_pal;
    bit e_hit, e_hs, e_vs, e_blank;

    bit rec = 0;
    int pal_q1[$];
    int pal_q2[$];
    int xs[$];
    int ys[$];

    always #10 Clk = ~Clk;

    // The registered rom_addr acts as the ROM's address register.
    assign rom_data = rom[rom_addr];

    snake_head_sprite_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .pixel_en   (pixel_en),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .blank_in   (blank_in),
        .head_x     (head_x),
        .head_y     (head_y),
        .head_dir   (head_dir),
        .head_vis   (head_vis),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pal_index  (pal_index),
        .sprite_hit (sprite_hit),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .blank_out  (blank_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Screen pixel -> source pixel by quarter turns (x,y)->(y,15-x).
    function automatic void ref_pix(input int x, input int y,
                                    input int sx, input int sy,
                                    input int d, output bit inb,
                                    output int addr);
        int c, r, t;
        inb = (x >= sx) && (x - sx < 16) && (y >= sy) && (y - sy < 16);
        c = x - sx;
        r = y - sy;
        for (int k = 0; k < d; k++) begin
            t = c;
            c = r;
            r = 15 - t;
        end
        addr = inb ? r * 16 + c : 0;
    endfunction

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_dir = 0; m_vis = 0; m_vsp = 1;
        p_addr = 0; p_hit = 0; p_hs = 1; p_vs = 1; p_blank = 0;
        e_pal = 0; e_hit = 0; e_hs = 1; e_vs = 1; e_blank = 0;
    endtask

    task automatic step(input bit en);
        bit inb;
        int a;
        pixel_en = en;
        @(posedge Clk);
        #1;
        if (en) begin
            e_pal   = int'(rom[p_addr]);
            e_hit   = p_hit && (rom[p_addr] != 4'h0);
            e_hs    = p_hs;
            e_vs    = p_vs;
            e_blank = p_blank;
            ref_pix(int'(DrawX), int'(DrawY), m_sx, m_sy, m_dir, inb, a);
            p_addr  = a;
            p_hit   = inb && m_vis;
            p_hs    = hs_in;
            p_vs    = vs_in;
            p_blank = blank_in;
            if (m_vsp && !vs_in) begin
                m_sx  = int'(head_x);
                m_sy  = int'(head_y);
                m_dir = int'(head_dir);
                m_vis = head_vis;
            end
            m_vsp = vs_in;
            if (rec) pal_q1.push_back(int'(pal_index));
        end
        chk("rom_addr", 32'(rom_addr), 32'(p_addr));
        chk("pal_index", 32'(pal_index), 32'(e_pal));
        chk("sprite_hit", 32'(sprite_hit), 32'(e_hit));
        chk("hs_out", 32'(hs_out), 32'(e_hs));
        chk("vs_out", 32'(vs_out), 32'(e_vs));
        chk("blank_out", 32'(blank_out), 32'(e_blank));
    endtask

    task automatic latch(input int x, input int y, input int d,
                         input bit vis);
        head_x = 10'(x);
        head_y = 10'(y);
        head_dir = dir_t'(d);
        head_vis = vis;
        vs_in = 1'b1;
        step(1);
        vs_in = 1'b0;
        step(1);
        vs_in = 1'b1;
        step(1);
    endtask

    task automatic at(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step(1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(1, 15));
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Reset asserted mid-line clears outputs before the next edge.
        latch(100, 50, 0, 1);
        at(105, 55);
        at(106, 55);
        #5;
        Reset_n = 1'b0;
        #1;
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_pal", 32'(pal_index), 0);
        chk("rst_hit", 32'(sprite_hit), 0);
        chk("rst_hs", 32'(hs_out), 1);
        chk("rst_vs", 32'(vs_out), 1);
        chk("rst_blank", 32'(blank_out), 0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        at(105, 55);
        at(106, 55);
        chk("rst_novis_hit", 32'(sprite_hit), 0);

        // UP facing addressing and right clip of the box.
        latch(100, 50, 0, 1);
        at(100, 50);
        chk("up_a0", 32'(rom_addr), 0);
        at(115, 50);
        chk("up_a15", 32'(rom_addr), 15);
        at(100, 51);
        chk("up_a16", 32'(rom_addr), 16);
        at(116, 50);
        at(0, 0);
        chk("up_out_hit", 32'(sprite_hit), 0);

        // Other facings.
        latch(0, 0, 1, 1);
        at(15, 0);
        chk("right_15_0", 32'(rom_addr), 0);
        at(0, 0);
        chk("right_0_0", 32'(rom_addr), 240);
        latch(0, 0, 3, 1);
        at(0, 0);
        chk("left_0_0", 32'(rom_addr), 15);
        latch(0, 0, 2, 1);
        at(0, 0);
        chk("down_0_0", 32'(rom_addr), 255);

        // Transparent key and opaque index latency.
        latch(100, 50, 0, 1);
        rom[0] = 4'h0;
        rom[16] = 4'h5;
        at(100, 50);
        at(300, 300);
        chk("transp_hit", 32'(sprite_hit), 0);
        at(100, 51);
        at(300, 300);
        chk("opaque_pal", 32'(pal_index), 5);
        chk("opaque_hit", 32'(sprite_hit), 1);

        // Mid-frame head move is deferred to the next vsync edge.
        rom[0] = 4'h7;
        head_x = 10'd200;
        at(100, 50);
        at(300, 300);
        chk("defer_old_hit", 32'(sprite_hit), 1);
        at(200, 50);
        at(300, 300);
        chk("defer_new_miss", 32'(sprite_hit), 0);
        latch(200, 50, 0, 1);
        at(200, 50);
        at(300, 300);
        chk("moved_hit", 32'(sprite_hit), 1);

        // Bottom-right corner: no wrap to column 0.
        latch(630, 470, 0, 1);
        rom[9] = 4'h3;
        at(639, 470);
        at(0, 470);
        chk("edge_hit", 32'(sprite_hit), 1);
        at(0, 470);
        chk("wrap_miss", 32'(sprite_hit), 0);

        // Same stream with pixel_en every Clk and every second Clk.
        for (int i = 0; i < 40; i++) begin
            xs.push_back($urandom_range(620, 639));
            ys.push_back($urandom_range(465, 489));
        end
        rec = 1;
        foreach (xs[i]) at(xs[i], ys[i]);
        at(0, 0);
        at(0, 0);
        pal_q2 = pal_q1;
        pal_q1.delete();
        foreach (xs[i]) begin
            DrawX = 10'(xs[i]);
            DrawY = 10'(ys[i]);
            step(1);
            step(0);
        end
        at(0, 0);
        at(0, 0);
        rec = 0;
        chk("duty_len", 32'(pal_q1.size()), 32'(pal_q2.size()));
        foreach (pal_q2[i]) begin
            if (i < pal_q1.size())
                chk("duty_pal", 32'(pal_q1[i]), 32'(pal_q2[i]));
        end

        // Random raster, strobe duty, syncs and head updates.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                head_x = 10'($urandom_range(0, 1023));
                head_y = 10'($urandom_range(0, 1023));
                head_dir = dir_t'($urandom_range(0, 3));
                head_vis = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 1) == 0) begin
                DrawX = head_x + 10'($urandom_range(0, 20)) - 10'd2;
                DrawY = head_y + 10'($urandom_range(0, 20)) - 10'd2;
            end else begin
                DrawX = 10'($urandom_range(0, 1023));
                DrawY = 10'($urandom_range(0, 1023));
            end
            hs_in = 1'($urandom_range(0, 1));
            vs_in = ($urandom_range(0, 7) != 0);
            blank_in = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
